alu_exec_stage: RTL and testbench

//  Pipelined ALU execute stage. Registers an operation (opcode, operands, shift amount), evaluates it

---
 rtl/alu_exec_stage.sv | 159 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined ALU execute stage: S1 holds the issued op, S2 holds the result.
// Valid/ready on both sides; the ready chain flows backward only, so no in_valid->in_ready path exists.

module barrel_shifter #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic [N-1:0] i_data,
  input  logic [M-1:0] i_shamt,
  input  logic         i_left,   // 1 selects arithmetic right, 0 selects logical left
  output logic [N-1:0] o_data
);
  logic [N-1:0] w_tmp;

  always_comb begin
    w_tmp = i_data;
    for (int i = 0; i < M; i++) begin
      if (i_shamt[i]) begin
        if (i_left) w_tmp = $signed(w_tmp) >>> (2**i);
        else        w_tmp = w_tmp << (2**i);
      end
    end
    o_data = w_tmp;
  end
endmodule

module alu_exec_stage #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_opcode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [M-1:0] in_shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_ovf,
  output logic         out_ne,
  output logic         out_lt,
  output logic         out_illegal
);
  localparam logic [4:0]   OP_ADD = 5'b00000;
  localparam logic [4:0]   OP_SUB = 5'b00001;
  localparam logic [4:0]   OP_AND = 5'b00010;
  localparam logic [4:0]   OP_OR  = 5'b00011;
  localparam logic [4:0]   OP_SLL = 5'b00100;
  localparam logic [4:0]   OP_SRA = 5'b00101;
  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};

  logic         r_s1_valid;
  logic [4:0]   r_op;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [M-1:0] r_shamt;

  logic         r_out_valid;
  logic [N-1:0] r_out_result;
  logic         r_out_ovf;
  logic         r_out_ne;
  logic         r_out_lt;
  logic         r_out_illegal;

  logic         w_s2_ready;
  logic         w_accept;
  logic         w_advance;
  logic [N-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic         w_ovf_add;
  logic         w_ovf_sub;
  logic [N-1:0] w_shift;
  logic         w_shift_right;
  logic [N-1:0] w_result;
  logic         w_ovf;
  logic         w_illegal;

  assign w_s2_ready = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_advance  = r_s1_valid && w_s2_ready;

  // The comparator flags always come from A-B, independent of the opcode.
  assign w_sum     = r_a + r_b;
  assign w_diff    = r_a + ~r_b + ONE;
  assign w_ovf_add = (r_a[N-1] == r_b[N-1])  && (w_sum[N-1]  != r_a[N-1]);
  assign w_ovf_sub = (r_a[N-1] == ~r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);

  assign w_shift_right = (r_op == OP_SRA);

  barrel_shifter #(.N(N), .M(M)) u_shifter (
    .i_data  (r_a),
    .i_shamt (r_shamt),
    .i_left  (w_shift_right),
    .o_data  (w_shift)
  );

  always_comb begin
    w_result  = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (r_op)
      OP_ADD: begin w_result = w_sum;  w_ovf = w_ovf_add; end
      OP_SUB: begin w_result = w_diff; w_ovf = w_ovf_sub; end
      OP_AND: w_result = r_a & r_b;
      OP_OR:  w_result = r_a | r_b;
      OP_SLL: w_result = w_shift;
      OP_SRA: w_result = w_shift;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_shamt       <= '0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_ovf     <= 1'b0;
      r_out_ne      <= 1'b0;
      r_out_lt      <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      if (w_advance) begin
        r_out_valid   <= 1'b1;
        r_out_result  <= w_result;
        r_out_ovf     <= w_ovf;
        r_out_ne      <= |w_diff;
        r_out_lt      <= w_diff[N-1] ^ w_ovf_sub;
        r_out_illegal <= w_illegal;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_op       <= in_opcode;
        r_a        <= in_a;
        r_b        <= in_b;
        r_shamt    <= in_shamt;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_ovf     = r_out_ovf;
  assign out_ne      = r_out_ne;
  assign out_lt      = r_out_lt;
  assign out_illegal = r_out_illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage; expected values are hand-computed constants.

module tb_alu_exec_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_ne;
  logic        out_lt;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_stage #(.N(32), .M(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_shamt    (in_shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_ne      (out_ne),
    .out_lt      (out_lt),
    .out_illegal (out_illegal)
  );

  always #5 clock = ~clock;

  // Drives one op with out_ready=1 and returns #1 after the edge that loads its result.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(posedge clock); #1;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_shamt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_vec++; if ({out_result, out_ovf, out_ne, out_lt, out_illegal} !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs got %h/%b%b%b%b exp 0", out_result, out_ovf, out_ne, out_lt, out_illegal); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    issue(5'b00000, 32'h7FFFFFFF, 32'h1, 5'd0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_vec++; if (out_result !== 32'h80000000) begin n_err++; $display("FAIL add_result got %h exp 80000000", out_result); end
    n_vec++; if ({out_ovf, out_lt, out_ne, out_illegal} !== 4'b1010) begin
      n_err++; $display("FAIL add_flags ovf/lt/ne/ill got %b exp 1010", {out_ovf, out_lt, out_ne, out_illegal}); end
    issue(5'b00001, 32'h80000000, 32'h1, 5'd0);
    n_vec++; if (out_result !== 32'h7FFFFFFF) begin n_err++; $display("FAIL sub_ovf_result got %h exp 7fffffff", out_result); end
    n_vec++; if ({out_ovf, out_lt, out_ne} !== 3'b111) begin
      n_err++; $display("FAIL sub_ovf_flags ovf/lt/ne got %b exp 111", {out_ovf, out_lt, out_ne}); end
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1;
    in_valid = 1'b1; in_opcode = 5'b00001; in_a = 32'h5; in_b = 32'h5;
    @(posedge clock); #1;
    in_a = 32'hFFFFFFFF; in_b = 32'h1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'h0) begin
      n_err++; $display("FAIL b2b_first got v=%b %h exp v=1 00000000", out_valid, out_result); end
    n_vec++; if ({out_ne, out_lt, out_ovf} !== 3'b000) begin
      n_err++; $display("FAIL b2b_first_flags ne/lt/ovf got %b exp 000", {out_ne, out_lt, out_ovf}); end
    @(posedge clock); #1;
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFE) begin
      n_err++; $display("FAIL b2b_second got v=%b %h exp v=1 fffffffe", out_valid, out_result); end
    n_vec++; if ({out_ne, out_lt, out_ovf} !== 3'b110) begin
      n_err++; $display("FAIL b2b_second_flags ne/lt/ovf got %b exp 110", {out_ne, out_lt, out_ovf}); end
    @(posedge clock); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_logic_shift();
    issue(5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    n_vec++; if (out_result !== 32'hF000F000 || out_ovf !== 1'b0) begin
      n_err++; $display("FAIL and got %h ovf=%b exp f000f000 ovf=0", out_result, out_ovf); end
    issue(5'b00011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    n_vec++; if (out_result !== 32'hFFF0FFF0) begin n_err++; $display("FAIL or got %h exp fff0fff0", out_result); end
    issue(5'b00100, 32'h1, 32'h0, 5'd31);
    n_vec++; if (out_result !== 32'h80000000 || {out_ne, out_lt} !== 2'b10) begin
      n_err++; $display("FAIL sll31 got %h ne/lt=%b exp 80000000 10", out_result, {out_ne, out_lt}); end
    issue(5'b00101, 32'h80000000, 32'h0, 5'd4);
    n_vec++; if (out_result !== 32'hF8000000 || {out_ne, out_lt, out_ovf} !== 3'b110) begin
      n_err++; $display("FAIL sra4 got %h ne/lt/ovf=%b exp f8000000 110", out_result, {out_ne, out_lt, out_ovf}); end
    issue(5'b00101, 32'h40000000, 32'h0, 5'd31);
    n_vec++; if (out_result !== 32'h0) begin n_err++; $display("FAIL sra31 got %h exp 00000000", out_result); end
    issue(5'b00101, 32'h80000001, 32'h0, 5'd0);
    n_vec++; if (out_result !== 32'h80000001) begin n_err++; $display("FAIL sra0 got %h exp 80000001", out_result); end
    issue(5'b00100, 32'h80000003, 32'h0, 5'd1);
    n_vec++; if (out_result !== 32'h00000006) begin n_err++; $display("FAIL sll1 got %h exp 00000006", out_result); end
  endtask

  task automatic test_illegal();
    issue(5'h1F, 32'h3, 32'h3, 5'd0);
    n_vec++; if (out_result !== 32'h0) begin n_err++; $display("FAIL illegal_result got %h exp 00000000", out_result); end
    n_vec++; if ({out_illegal, out_ovf, out_ne, out_lt} !== 4'b1000) begin
      n_err++; $display("FAIL illegal_flags ill/ovf/ne/lt got %b exp 1000", {out_illegal, out_ovf, out_ne, out_lt}); end
    issue(5'b00110, 32'h1, 32'h2, 5'd0);
    n_vec++; if ({out_illegal, out_ne, out_lt} !== 3'b111 || out_result !== 32'h0) begin
      n_err++; $display("FAIL illegal6 ill/ne/lt got %b res %h exp 111 00000000", {out_illegal, out_ne, out_lt}, out_result); end
  endtask

  task automatic test_stall();
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 5'b00000; in_a = 32'd1; in_b = 32'd1;
    @(posedge clock); #1;
    in_a = 32'd2; in_b = 32'd3;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_second_ready got %b exp 1", in_ready); end
    @(posedge clock); #1;
    in_a = 32'd10; in_b = 32'd20;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready got %b exp 0", in_ready); end
    @(posedge clock); #1;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd2) begin
      n_err++; $display("FAIL stall_hold got rdy=%b v=%b %h exp rdy=0 v=1 00000002", in_ready, out_valid, out_result); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1 || out_result !== 32'd2) begin
      n_err++; $display("FAIL stall_release got rdy=%b %h exp rdy=1 00000002", in_ready, out_result); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'd5) begin
      n_err++; $display("FAIL stall_second_out got v=%b %h exp v=1 00000005", out_valid, out_result); end
    @(posedge clock); #1;
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'd30) begin
      n_err++; $display("FAIL stall_third_out got v=%b %h exp v=1 0000001e", out_valid, out_result); end
    @(posedge clock); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 5'b00001; in_a = 32'd9; in_b = 32'd4;
    repeat (2) @(posedge clock);
    #2;
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL areset_prefill got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); end
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_ne !== 1'b0) begin
      n_err++; $display("FAIL areset_clear got v=%b rdy=%b %h ne=%b exp 0 1 00000000 0", out_valid, in_ready, out_result, out_ne); end
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_stale cycle %0d got v=%b exp 0", i, out_valid); end
    end
    issue(5'b00000, 32'd7, 32'd8, 5'd0);
    n_vec++; if (out_valid !== 1'b1 || out_result !== 32'd15) begin
      n_err++; $display("FAIL areset_after got v=%b %h exp v=1 0000000f", out_valid, out_result); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_shift();
    test_illegal();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
